// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the architectural PC and runs a
// single-outstanding imem request/response exchange for the decoder.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_fault,
  output logic        fetch_busy
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } state_t;

  state_t state;
  logic   pc_bad;
  logic   tgt_bad;
  logic   accepted;
  logic   rsp_due;
  logic   in_flight;

  assign pc_bad  = pc[1:0] != 2'b00;
  assign tgt_bad = next_pc[1:0] != 2'b00;

  assign imem_req_valid = (state == REQ) && !pc_bad;
  assign imem_req_addr  = pc;
  assign fetch_busy     = ~instr_valid;

  assign accepted = imem_req_valid && imem_req_ready;
  assign rsp_due  = (state == WAIT) || (state == DRAIN);

  // A redirect must never orphan a response still on its way back.
  assign in_flight = accepted || (rsp_due && !imem_rsp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (flush) begin
      pc          <= next_pc;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      if (in_flight) begin
        state <= DRAIN;
      end else if (tgt_bad) begin
        state       <= HOLD;
        instr       <= NOP;
        instr_valid <= 1'b1;
        fetch_fault <= 1'b1;
      end else begin
        state <= REQ;
      end
    end else begin
      unique case (state)
        REQ: begin
          if (pc_bad) begin
            state       <= HOLD;
            instr       <= NOP;
            instr_valid <= 1'b1;
            fetch_fault <= 1'b1;
          end else if (imem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            state       <= HOLD;
            instr       <= imem_rsp_data;
            instr_valid <= 1'b1;
            fetch_fault <= imem_rsp_err;
          end
        end
        HOLD: begin
          if (!stall) begin
            pc <= next_pc;
            if (tgt_bad) begin
              instr       <= NOP;
              fetch_fault <= 1'b1;
            end else begin
              state       <= REQ;
              instr_valid <= 1'b0;
              fetch_fault <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (imem_rsp_valid) begin
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule
